// File: rtl/chronos_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// chronos_pkg : shared fetch-path types and constants for the Chronos RV32I core
// Revision    : 1.0
// ----------------------------------------------------------------------------
package chronos_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_FULL = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_buf : circular instruction buffer with push/pop/flush and occupancy count
// Revision  : 1.0
// ----------------------------------------------------------------------------
module fetch_buf
  import chronos_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wr_entry_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_entry_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : instruction-fetch initiator; owns the PC, one outstanding request,
//              buffers responses for decode. FETCH_PERF_CNT_EN adds perf counters.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module fetch_unit
  import chronos_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] fetch_addr,
  output logic            fetch_req,
  input  logic [XLEN-1:0] request_data,
  input  logic            fetch_data_valid,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t    head, wr_entry;

  // fetch_req decodes straight from the state register so reset drops it at once.
  assign fetch_req  = (state_q == ST_REQ);
  assign fetch_addr = pc_q;
  assign inst_valid = !buf_empty;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;

  // A redirect discards both the same-edge response and the same-edge consume.
  assign push = fetch_req && fetch_data_valid && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  assign wr_entry.pc   = pc_q;
  assign wr_entry.inst = request_data;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = ST_REQ;
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (push) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
            if (!pop && (buf_count == CNT_W'(BUF_DEPTH - 1))) state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .count_o    (buf_count),
    .empty_o    (buf_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 1'b1;
      if ((fetch_req && !fetch_data_valid) || (state_q == ST_FULL))
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_unit : table, directed and randomized checks of fetch_unit
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic [31:0] request_data = '0;
  logic        fetch_data_valid = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RPC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_addr       (fetch_addr),
    .fetch_req        (fetch_req),
    .request_data     (request_data),
    .fetch_data_valid (fetch_data_valid),
    .inst_valid       (inst_valid),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .inst_ready       (inst_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall       (perf_stall)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered queue of fetched {pc, word} and the next PC.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_started;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl [14];

  logic [9:0] dvp;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = RPC;
    m_started = 1'b0;
  endtask

  // Drive inputs just after an edge, then compare against the model mid-cycle.
  task automatic drive_sample(input logic rdy, input logic dv, input logic redir,
                              input logic [31:0] rpc);
    bit exp_req;
    inst_ready       = rdy;
    fetch_data_valid = dv;
    redirect_valid   = redir;
    redirect_pc      = rpc;
    request_data     = dv ? memfn(fetch_addr) : $urandom;
    @(negedge clk);
    exp_req = m_started && (m_q.size() < DEPTH);
    chk("fetch_req", 32'(fetch_req), 32'(exp_req));
    chk("fetch_addr", fetch_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("inst_pc", inst_pc, m_q[0].pc);
      chk("inst_data", inst_data, m_q[0].data);
    end
  endtask

  task automatic edge_step();
    bit   req;
    ent_t e;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc      = {redirect_pc[31:2], 2'b00};
      m_started = 1'b1;
    end else begin
      req = m_started && (m_q.size() < DEPTH);
      if ((m_q.size() != 0) && inst_ready) void'(m_q.pop_front());
      if (req && fetch_data_valid) begin
        e.pc   = m_pc;
        e.data = memfn(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      m_started = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      drive_sample(1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      edge_step();
    end
    rst = 1'b1;
  endtask

  initial begin
    logic rdy, dv, redir;
    int   wcnt;

    tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h0};
    for (int i = 3; i <= 9; i++) tbl[i] = '{1'b0, 1'b0, 32'h8, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    tbl[12] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h8};
    tbl[13] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
    dvp = 10'b01_1110_0010;

    // Zero-latency memory, decode stalled for 10 cycles, then draining.
    do_reset(3);
    foreach (tbl[i]) begin
      drive_sample(tbl[i].rdy, 1'b1, 1'b0, 32'h0);
      chk("tbl_req", 32'(fetch_req), 32'(tbl[i].exp_req));
      chk("tbl_addr", fetch_addr, tbl[i].exp_addr);
      chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk("tbl_pc", inst_pc, tbl[i].exp_pc);
        chk("tbl_data", inst_data, memfn(tbl[i].exp_pc));
      end
      edge_step();
    end

    // Response for 0x4 delayed by three cycles.
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      drive_sample(1'b1, dvp[c], 1'b0, 32'h0);
      if (c >= 2 && c <= 4) begin
        chk("dly_req", 32'(fetch_req), 32'd1);
        chk("dly_addr", fetch_addr, 32'h4);
      end
      if (c == 5) chk("dly_valid5", 32'(inst_valid), 32'd0);
      if (c == 6) chk("dly_pc6", inst_pc, 32'h4);
      if (c == 7) chk("dly_pc7", inst_pc, 32'h8);
`ifdef FETCH_PERF_CNT_EN
      if (c == 9) begin
        chk("perf_fetched", perf_fetched, 32'd5);
        chk("perf_stall", perf_stall, 32'd3);
      end
`endif
      edge_step();
    end

    // Redirect while full, then a redirect racing an in-flight response.
    do_reset(2);
    drive_sample(1'b0, 1'b0, 1'b0, 32'h0);   edge_step();
    drive_sample(1'b0, 1'b1, 1'b0, 32'h0);   edge_step();
    drive_sample(1'b0, 1'b1, 1'b0, 32'h0);   edge_step();
    drive_sample(1'b1, 1'b1, 1'b1, 32'h103);
    chk("rd_full_req", 32'(fetch_req), 32'd0);
    chk("rd_full_pc", inst_pc, 32'h0);
    edge_step();
    drive_sample(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rd_flush_valid", 32'(inst_valid), 32'd0);
    chk("rd_new_addr", fetch_addr, 32'h100);
    edge_step();
    drive_sample(1'b1, 1'b1, 1'b1, 32'h20);
    chk("rd_new_pc", inst_pc, 32'h100);
    chk("rd_new_data", inst_data, memfn(32'h100));
    edge_step();
    drive_sample(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rd2_valid", 32'(inst_valid), 32'd0);
    chk("rd2_addr", fetch_addr, 32'h20);
    edge_step();

    // Asynchronous reset in the middle of an outstanding request.
    do_reset(2);
    drive_sample(1'b0, 1'b0, 1'b0, 32'h0); edge_step();
    drive_sample(1'b0, 1'b1, 1'b0, 32'h0); edge_step();
    fetch_data_valid = 1'b0;
    #2;
    chk("mid_req_before", 32'(fetch_req), 32'd1);
    chk("mid_valid_before", 32'(inst_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_req_async", 32'(fetch_req), 32'd0);
    chk("mid_valid_async", 32'(inst_valid), 32'd0);
    chk("mid_addr_async", fetch_addr, RPC);
    @(posedge clk);
    #1;
    do_reset(2);
    drive_sample(1'b1, 1'b1, 1'b0, 32'h0); edge_step();
    drive_sample(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_addr", fetch_addr, RPC);
    chk("restart_req", 32'(fetch_req), 32'd1);
    edge_step();

    // Randomized traffic: variable memory latency, decode back-pressure, redirects.
    wcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 24) == 0);
      if (fetch_req) begin
        if (wcnt == 0) begin
          dv   = 1'b1;
          wcnt = $urandom_range(0, 3);
        end else begin
          dv   = 1'b0;
          wcnt = wcnt - 1;
        end
      end else begin
        dv = ($urandom_range(0, 3) == 0);
      end
      drive_sample(rdy, dv, redir, $urandom);
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the Chronos RV32I core; drives the instruction memory's fetch request interface and buffers returned words for decode.
- Owns the program counter. Issues word-aligned requests and accepts responses, including zero-latency (same-cycle) ones.
- Presents instructions to decode through a valid/ready handshake. Accepts branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetch_addr  output  32  byte address of requested word; bits [1:0] always 0.
- fetch_req  output  1  request strobe to instruction memory.
- request_data  input  32  instruction word from memory; valid only with fetch_data_valid.
- fetch_data_valid  input  1  response strobe; may assert in the same cycle as fetch_req.
- inst_valid  output  1  buffer head holds an instruction for decode.
- inst_data  output  32  head instruction.
- inst_pc  output  32  PC of the head instruction.
- inst_ready  input  1  decode consumes the head when inst_valid and inst_ready are both high.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  new PC; bits [1:0] forced to 0 internally.

Behaviour:
- Reset (rst low, asynchronous) sets:
  - pc = RESET_PC, state = IDLE, buffer empty;
  - fetch_req = 0, fetch_addr = RESET_PC;
  - inst_valid = 0, inst_data = 0, inst_pc = 0.
  Release is synchronous to the next edge.
- FSM states: IDLE, REQ, FULL.
  - IDLE: one cycle after reset release. Then → REQ.
  - REQ:
    - fetch_req = 1 and fetch_addr = pc, held stable until a cycle where fetch_data_valid = 1.
    - On that edge: push {pc, request_data} into the buffer, pc += 4 (wraps modulo 2^32).
    - If the buffer becomes full after the push and there is no simultaneous pop → FULL. Otherwise stay in REQ.
  - FULL: fetch_req = 0. → REQ on the edge where a pop occurs.
- At most one outstanding request. fetch_addr is registered from pc; it is never combinational from redirect_pc.
- Responses with fetch_data_valid high while fetch_req is low are ignored.
- Buffer is a circular FIFO with BUF_DEPTH entries and an occupancy count:
  - push and pop in the same cycle: count unchanged;
  - push is never attempted when full;
  - pop when empty is impossible because inst_valid = 0.
- inst_valid = (count != 0). inst_data and inst_pc are the head entry; there is no bypass from request_data, so response-to-decode latency is 1 cycle minimum.
- Redirect (redirect_valid = 1 at an edge), highest priority:
  - buffer flushed to count 0; any same-edge response discarded; any same-edge pop ignored;
  - pc = {redirect_pc[31:2], 2'b00}; state → REQ;
  - first request at the new PC is driven the following cycle.
- Back-to-back redirects: the last one wins.
- Reset asserted mid-request: fetch_req drops immediately (asynchronous) and all state returns to reset values.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two 32-bit outputs:
  - perf_fetched: count of accepted responses;
  - perf_stall: count of cycles spent in REQ with fetch_data_valid = 0, or in FULL.
  Both clear on reset, wrap modulo 2^32, and are not cleared by redirect.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package chronos_pkg:
  - fetch FSM state typedef (IDLE/REQ/FULL);
  - XLEN = 32 and INST_BYTES = 4;
  - RESET_PC default constant.
- One natural sub-module: fetch_buf, the parameterised FIFO with push/pop/flush/count, instantiated once.

Test Plan:
- Zero-latency memory, inst_ready held 1, RESET_PC = 0:
  - inst_pc sequence 0x0, 0x4, 0x8, … with inst_data matching the memory words;
  - first inst_valid 2 cycles after reset release.
- inst_ready = 0 for 10 cycles:
  - exactly BUF_DEPTH = 2 entries fill (PCs 0x0, 0x4);
  - fetch_req low in FULL and fetch_addr = 0x8;
  - after inst_ready returns to 1, fetching resumes at 0x8 with no duplicated or skipped PC.
- Memory delays fetch_data_valid by 3 cycles: fetch_req and fetch_addr = 0x4 stay constant for all 3 cycles; one push only.
- redirect_valid with redirect_pc = 0x103 while 2 entries are buffered and a response arrives the same cycle:
  - buffer empties and the response is dropped;
  - next fetch_addr = 0x100; next inst_pc = 0x100.
- Assert rst low mid-REQ: fetch_req = 0 and inst_valid = 0 before the next clk edge; after release, fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN, 5 fetches plus 3 wait cycles in the delay scenario: perf_fetched = 5, perf_stall = 3.
